// File: rtl/idex_stage_r0.sv
`default_nettype none
// ============================================================================
// Module   : idex_stage_r0
// Purpose  : ID/EX pipeline register in front of a combinational ALU.
//            Captures decoded operands/controls, extends the immediate,
//            forwards EX/MEM and MEM/WB results onto the registered source
//            indices, packs the A/B operand lanes onto dataOut and raises
//            stall_req on a load-use hazard (loading a bubble next cycle).
// Ports    : clk, rst (sync, active-high), en_n (1 = hold), flush,
//            id_*      decoded instruction from ID,
//            exmem_*   / memwb_* forwarding sources,
//            dataOut   {A lane, B lane}, ctrl, shamt to the ALU,
//            ex_*      registered destination/controls/store data/valid,
//            stall_req load-use hazard towards ID and PC.
// Revision : r0 - initial release
// ============================================================================
module idex_stage_r0 #(
    parameter int DATA_WIDTH     = 32,
    parameter int CTRL_WIDTH     = 5,
    parameter int SHAMT_WIDTH    = 5,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_n,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [DATA_WIDTH-1:0]     id_rsData,
    input  logic [DATA_WIDTH-1:0]     id_rtData,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [15:0]               id_imm16,
    input  logic                      id_immSigned,
    input  logic                      id_useImm,
    input  logic [CTRL_WIDTH-1:0]     id_ctrl,
    input  logic [SHAMT_WIDTH-1:0]    id_shamt,
    input  logic                      id_regWrite,
    input  logic                      id_memRead,
    input  logic                      id_memWrite,
    input  logic                      exmem_regWrite,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic [DATA_WIDTH-1:0]     exmem_data,
    input  logic                      memwb_regWrite,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic [DATA_WIDTH-1:0]     memwb_data,
    output logic [2*DATA_WIDTH-1:0]   dataOut,
    output logic [CTRL_WIDTH-1:0]     ctrl,
    output logic [SHAMT_WIDTH-1:0]    shamt,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      ex_regWrite,
    output logic                      ex_memRead,
    output logic                      ex_memWrite,
    output logic [DATA_WIDTH-1:0]     ex_storeData,
    output logic                      ex_valid,
    output logic                      stall_req
);

    // mthi / mtlo carry rs on the B lane
    localparam logic [CTRL_WIDTH-1:0] C_CTRL_MTHI = CTRL_WIDTH'(5'b01011);
    localparam logic [CTRL_WIDTH-1:0] C_CTRL_MTLO = CTRL_WIDTH'(5'b01100);

    logic                      r_valid;
    logic                      r_regWrite;
    logic                      r_memRead;
    logic                      r_memWrite;
    logic [CTRL_WIDTH-1:0]     r_ctrl;
    logic [SHAMT_WIDTH-1:0]    r_shamt;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [REG_ADDR_WIDTH-1:0] r_rs;
    logic [REG_ADDR_WIDTH-1:0] r_rt;
    logic [DATA_WIDTH-1:0]     r_rs_data;
    logic [DATA_WIDTH-1:0]     r_rt_data;
    logic [DATA_WIDTH-1:0]     r_imm_ext;
    logic                      r_use_imm;

    logic [DATA_WIDTH-1:0]     w_imm_ext;
    logic [DATA_WIDTH-1:0]     w_fwd_rs;
    logic [DATA_WIDTH-1:0]     w_fwd_rt;
    logic [DATA_WIDTH-1:0]     w_lane_b;
    logic                      w_bubble;

    // Extension happens before the register so EX sees a ready operand
    assign w_imm_ext = id_immSigned ? {{(DATA_WIDTH-16){id_imm16[15]}}, id_imm16}
                                    : {{(DATA_WIDTH-16){1'b0}}, id_imm16};

    // Load-use: the load result is not available until after MEM, so an
    // immediate-form consumer only hazards on rs.
    assign stall_req = r_valid && r_memRead && (r_rd != '0) && id_valid &&
                       ((r_rd == id_rs) || ((r_rd == id_rt) && !id_useImm));

    assign w_bubble = flush || stall_req;

    function automatic logic [DATA_WIDTH-1:0] fwd(
        input logic [REG_ADDR_WIDTH-1:0] idx,
        input logic [DATA_WIDTH-1:0]     reg_val
    );
        logic [DATA_WIDTH-1:0] v;
        v = reg_val;
        if (idx != '0) begin
            if (exmem_regWrite && (exmem_rd == idx))
                v = exmem_data;
            else if (memwb_regWrite && (memwb_rd == idx))
                v = memwb_data;
        end
        return v;
    endfunction

    assign w_fwd_rs = fwd(r_rs, r_rs_data);
    assign w_fwd_rt = fwd(r_rt, r_rt_data);

    always_comb begin
        w_lane_b = w_fwd_rt;
        if (r_use_imm)
            w_lane_b = r_imm_ext;
        else if ((r_ctrl == C_CTRL_MTHI) || (r_ctrl == C_CTRL_MTLO))
            w_lane_b = w_fwd_rs;
    end

    assign dataOut      = {w_fwd_rs, w_lane_b};
    assign ex_storeData = w_fwd_rt;
    assign ctrl         = r_ctrl;
    assign shamt        = r_shamt;
    assign ex_rd        = r_rd;
    assign ex_regWrite  = r_regWrite;
    assign ex_memRead   = r_memRead;
    assign ex_memWrite  = r_memWrite;
    assign ex_valid     = r_valid;

    always_ff @(posedge clk) begin
        if (rst || (!en_n && w_bubble)) begin
            r_valid    <= 1'b0;
            r_regWrite <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_ctrl     <= '0;
            r_shamt    <= '0;
            r_rd       <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm_ext  <= '0;
            r_use_imm  <= 1'b0;
        end else if (!en_n) begin
            r_valid    <= id_valid;
            r_regWrite <= id_valid && id_regWrite;
            r_memRead  <= id_valid && id_memRead;
            r_memWrite <= id_valid && id_memWrite;
            r_ctrl     <= id_ctrl;
            r_shamt    <= id_shamt;
            r_rd       <= id_rd;
            r_rs       <= id_rs;
            r_rt       <= id_rt;
            r_rs_data  <= id_rsData;
            r_rt_data  <= id_rtData;
            r_imm_ext  <= w_imm_ext;
            r_use_imm  <= id_useImm;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_idex_stage_r0.sv
`default_nettype none
// ============================================================================
// Module   : tb_idex_stage_r0
// Purpose  : Directed self-checking bench for idex_stage_r0 with
//            hand-computed expected values.
// Revision : r0 - initial release
// ============================================================================
module tb_idex_stage_r0;

    logic        clk = 1'b0;
    logic        rst, en_n, flush, id_valid;
    logic [31:0] id_rsData, id_rtData;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm16;
    logic        id_immSigned, id_useImm;
    logic [4:0]  id_ctrl, id_shamt;
    logic        id_regWrite, id_memRead, id_memWrite;
    logic        exmem_regWrite, memwb_regWrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_data, memwb_data;
    logic [63:0] dataOut;
    logic [4:0]  ctrl, shamt, ex_rd;
    logic        ex_regWrite, ex_memRead, ex_memWrite, ex_valid, stall_req;
    logic [31:0] ex_storeData;

    int n_checks = 0;
    int n_errors = 0;

    idex_stage_r0 dut (
        .clk(clk), .rst(rst), .en_n(en_n), .flush(flush), .id_valid(id_valid),
        .id_rsData(id_rsData), .id_rtData(id_rtData), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_imm16(id_imm16), .id_immSigned(id_immSigned),
        .id_useImm(id_useImm), .id_ctrl(id_ctrl), .id_shamt(id_shamt),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
        .exmem_regWrite(exmem_regWrite), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_regWrite(memwb_regWrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .dataOut(dataOut), .ctrl(ctrl), .shamt(shamt), .ex_rd(ex_rd),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_storeData(ex_storeData), .ex_valid(ex_valid), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic no_fwd();
        exmem_regWrite = 0; exmem_rd = 0; exmem_data = 0;
        memwb_regWrite = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    task automatic id_set(input logic [4:0] rs, input logic [31:0] rsd,
                          input logic [4:0] rt, input logic [31:0] rtd,
                          input logic [4:0] rd, input logic [15:0] imm,
                          input logic sgn, input logic use_imm, input logic [4:0] c,
                          input logic rw, input logic mr, input logic mw);
        id_valid = 1; id_rs = rs; id_rsData = rsd; id_rt = rt; id_rtData = rtd;
        id_rd = rd; id_imm16 = imm; id_immSigned = sgn; id_useImm = use_imm;
        id_ctrl = c; id_shamt = 0; id_regWrite = rw; id_memRead = mr; id_memWrite = mw;
    endtask

    initial begin
        rst = 1; en_n = 0; flush = 0;
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        id_valid = 0;
        no_fwd();

        // Reset
        step();
        check("rst_valid", 64'(ex_valid), 64'd0);
        check("rst_data", dataOut, 64'd0);
        check("rst_ctrl", 64'({ctrl, shamt, ex_rd}), 64'd0);
        check("rst_store", 64'(ex_storeData), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        rst = 0;

        // addi with sign-extended -1
        id_set(1, 32'd5, 2, 32'd0, 2, 16'hFFFF, 1, 1, 5'd0, 1, 0, 0);
        step();
        check("addi_data", dataOut, {32'd5, 32'hFFFF_FFFF});
        check("addi_valid", 64'(ex_valid), 64'd1);
        check("addi_rd_rw", 64'({ex_rd, ex_regWrite}), 64'({5'd2, 1'b1}));

        // zero extension
        id_set(1, 32'd5, 2, 32'd0, 2, 16'h8001, 0, 1, 5'd0, 1, 0, 0);
        step();
        check("zext_data", dataOut, {32'd5, 32'h0000_8001});

        // Forward priority on rs=3
        id_set(3, 32'h11, 5, 32'h22, 6, 0, 0, 0, 5'd0, 1, 0, 0);
        step();
        check("fwd_none", dataOut, {32'h11, 32'h22});
        exmem_regWrite = 1; exmem_rd = 3; exmem_data = 32'hAA;
        memwb_regWrite = 1; memwb_rd = 3; memwb_data = 32'hBB;
        #1;
        check("fwd_exmem_pri", dataOut, {32'hAA, 32'h22});
        exmem_regWrite = 0;
        #1;
        check("fwd_memwb", dataOut, {32'hBB, 32'h22});
        exmem_regWrite = 1; exmem_rd = 5;
        #1;
        check("fwd_rt_exmem", dataOut, {32'hBB, 32'hAA});
        no_fwd();

        // Index 0 never forwarded
        id_set(0, 32'h33, 0, 32'h44, 6, 0, 0, 0, 5'd0, 1, 0, 0);
        step();
        exmem_regWrite = 1; exmem_rd = 0; exmem_data = 32'hAA;
        memwb_regWrite = 1; memwb_rd = 0; memwb_data = 32'hBB;
        #1;
        check("fwd_zero_idx", dataOut, {32'h33, 32'h44});
        no_fwd();

        // Load-use: lw $4, 4($1)
        id_set(1, 32'h100, 4, 32'h0, 4, 16'd4, 1, 1, 5'd0, 1, 1, 0);
        step();
        check("lw_memread", 64'(ex_memRead), 64'd1);
        id_set(2, 32'h10, 4, 32'h0, 7, 16'd0, 1, 1, 5'd0, 1, 0, 0);
        #1;
        check("lu_imm_rt_nostall", 64'(stall_req), 64'd0);
        id_useImm = 0;
        #1;
        check("lu_stall", 64'(stall_req), 64'd1);
        step();
        check("lu_bubble", 64'({ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ctrl, ex_rd}), 64'd0);
        check("lu_bubble_data", dataOut, 64'd0);
        check("lu_stall_clear", 64'(stall_req), 64'd0);
        memwb_regWrite = 1; memwb_rd = 4; memwb_data = 32'h5555;
        step();
        check("lu_recap_valid", 64'(ex_valid), 64'd1);
        check("lu_recap_data", dataOut, {32'h10, 32'h5555});
        no_fwd();

        // mthi: B lane carries rs
        id_set(2, 32'h1234, 3, 32'h9, 0, 0, 0, 0, 5'b01011, 0, 0, 0);
        step();
        check("mthi_data", dataOut, {32'h1234, 32'h1234});
        check("mthi_store", 64'(ex_storeData), 64'h9);

        // sw with rt forwarded from EX/MEM
        id_set(1, 32'h200, 5, 32'h1, 0, 16'd8, 1, 1, 5'd0, 0, 0, 1);
        step();
        exmem_regWrite = 1; exmem_rd = 5; exmem_data = 32'h77;
        #1;
        check("sw_store_fwd", 64'(ex_storeData), 64'h77);
        check("sw_data", dataOut, {32'h200, 32'h8});

        // Hold for three cycles while ID changes
        en_n = 1;
        for (int i = 0; i < 3; i++) begin
            id_set(5'(i + 9), 32'(i + 100), 5'(i + 10), 32'hDEAD, 5'(i + 11), 16'h1, 0, 0,
                   5'd3, 1, 0, 0);
            step();
            check("hold_data", dataOut, {32'h200, 32'h8});
            check("hold_ctl", 64'({ex_memWrite, ex_regWrite, ctrl}), 64'({1'b1, 1'b0, 5'd0}));
        end
        en_n = 0;
        no_fwd();

        // flush coinciding with stall: one bubble only
        id_set(1, 32'h100, 4, 32'h0, 4, 16'd4, 1, 1, 5'd0, 1, 1, 0);
        step();
        id_set(4, 32'h0, 6, 32'h66, 8, 16'd0, 0, 0, 5'd0, 1, 0, 0);
        flush = 1;
        #1;
        check("fl_stall_req", 64'(stall_req), 64'd1);
        step();
        flush = 0;
        check("fl_bubble", 64'({ex_valid, ex_regWrite, ex_memRead, ex_rd}), 64'd0);
        step();
        check("fl_recap", 64'({ex_valid, ex_rd}), 64'({1'b1, 5'd8}));
        check("fl_recap_data", dataOut, {32'h0, 32'h66});

        // Reset overrides hold
        en_n = 1; rst = 1;
        step();
        rst = 0; en_n = 0;
        check("rst2_data", dataOut, 64'd0);
        check("rst2_ctl", 64'({ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ctrl, shamt, ex_rd}), 64'd0);
        check("rst2_store", 64'(ex_storeData), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/idex_stage_r0.md
Name: idex_stage_r0

Overview:
- ID/EX pipeline stage directly upstream of the EX-stage ALU.
- Registers decoded operands and control from ID, and forwards results from EX/MEM and MEM/WB.
- Selects immediate versus register operands and packs the two ALU operand lanes onto the ALU's dataIn bus.
- Detects load-use hazards and inserts bubbles; the downstream ALU is combinational (DELAY=0).

Parameters:
DATA_WIDTH, 32, operand/data width
CTRL_WIDTH, 5, ALU control code width
SHAMT_WIDTH, 5, shift amount width
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en_n  in  1  active-low stage enable; 1 = hold all registers
flush  in  1  replace captured instruction with bubble (branch/jump redirect)
id_valid  in  1  ID holds a real instruction
id_rsData  in  DATA_WIDTH  register-file rs read value
id_rtData  in  DATA_WIDTH  register-file rt read value
id_rs  in  REG_ADDR_WIDTH  rs index
id_rt  in  REG_ADDR_WIDTH  rt index
id_rd  in  REG_ADDR_WIDTH  destination index (already rt/rd selected)
id_imm16  in  16  raw immediate
id_immSigned  in  1  1 = sign-extend, 0 = zero-extend
id_useImm  in  1  B lane takes extended immediate
id_ctrl  in  CTRL_WIDTH  ALU control code
id_shamt  in  SHAMT_WIDTH  shift amount
id_regWrite, id_memRead, id_memWrite  in  1 each  stage controls
exmem_regWrite  in  1  EX/MEM writes a register
exmem_rd  in  REG_ADDR_WIDTH  EX/MEM destination
exmem_data  in  DATA_WIDTH  EX/MEM ALU result
memwb_regWrite  in  1  MEM/WB writes a register
memwb_rd  in  REG_ADDR_WIDTH  MEM/WB destination
memwb_data  in  DATA_WIDTH  MEM/WB writeback value
dataOut  out  2*DATA_WIDTH  ALU operands: [2*DW-1:DW] = A lane, [DW-1:0] = B lane
ctrl  out  CTRL_WIDTH  to ALU ctrl
shamt  out  SHAMT_WIDTH  to ALU shamt
ex_rd  out  REG_ADDR_WIDTH  registered destination
ex_regWrite, ex_memRead, ex_memWrite  out  1 each  registered controls
ex_storeData  out  DATA_WIDTH  forwarded rt value for stores
ex_valid  out  1  EX holds a real instruction
stall_req  out  1  load-use hazard; ID and PC must hold

Behaviour:
- Reset (rst=1 at posedge): all registers cleared. Outputs become ex_valid=0, all controls 0, ctrl=0, shamt=0, ex_rd=0, and all internal operand/index registers 0, so dataOut=0 and ex_storeData=0. Reset overrides en_n and flush.
- Update priority each posedge: rst, then en_n=1 (hold everything, including a pending bubble), then flush or stall_req (load bubble), then capture ID. Latency is 1 cycle ID to EX.
- Bubble: ex_valid=0, regWrite/memRead/memWrite=0, ctrl=0, shamt=0, rd=0, operand registers=0.
- Capture: register rsData, rtData, rs, rt, rd, the extended immediate, useImm, ctrl, shamt and controls; ex_valid=id_valid. When id_valid=0, all controls are registered as 0.
- Extension: sign-extend replicates imm16[15]; zero-extend pads with zeros. Extension is done before registering.
- Forwarding is combinational on the registered indices.
  - Per source (rs, rt): use exmem_data if exmem_regWrite and exmem_rd==index; else memwb_data if memwb_regWrite and memwb_rd==index; else the registered value.
  - Index 0 is never forwarded; it always uses the registered value.
  - EX/MEM has priority when both stages match.
- Lane packing:
  - A = fwdRs.
  - B = extended immediate if useImm; else fwdRs if ctrl is 01011 (mthi) or 01100 (mtlo); else fwdRt.
  - ex_storeData = fwdRt, always.
- Shifts: the ALU shifts B by shamt or by A. sll/srl/sra therefore place rt on B; sllv/srlv/srav place rs on A and rt on B. No special case is needed.
- Load-use: stall_req=1 combinationally when all of the following hold:
  - ex_valid and ex_memRead;
  - ex_rd!=0;
  - id_valid;
  - ex_rd==id_rs, or (ex_rd==id_rt and id_useImm=0).
- On stall_req with en_n=0, a bubble is loaded next cycle. Upstream holds ID, so the instruction is re-presented and captured on the following cycle.
- stall_req is evaluated even when en_n=1, but has no effect on this stage's state while held.
- Simultaneous flush and stall_req: a single bubble is loaded (flush semantics).

Test Plan:
- Reset then addi: id_rsData=5, id_imm16=16'hFFFF, id_immSigned=1, id_useImm=1, ctrl=0 -> next cycle dataOut={32'd5, 32'hFFFFFFFF}, ex_valid=1.
- Forward priority: EX rs=3; exmem_rd=3 data=0xAA, memwb_rd=3 data=0xBB, both write -> A lane=0xAA. Drop exmem_regWrite -> A=0xBB. With rs=0 and both rd=0 -> A=registered value.
- Load-use: lw to $4 in EX (ex_memRead=1), ID add using rt=$4 -> stall_req=1. Next cycle ex_valid=0 and controls 0. On the re-capture cycle, A/B come from MEM/WB forwarding of $4.
- mthi: ID rs=$2=0x1234, rt=$3=0x9, ctrl=01011 -> B lane=0x1234. sw with rt forwarded from EX/MEM 0x77 -> ex_storeData=0x77.
- en_n=1 for 3 cycles while ID inputs change -> outputs frozen. flush=1 with stall_req=1 -> a single bubble. rst asserted mid-stream with en_n=1 -> all outputs 0 next cycle.
